// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw inputs, clear strobe and conditioned outputs of the two-channel conditioner
interface input_conditioner_if #(
  parameter int GLITCH_W = 8
);
  logic                raw_in_1;
  logic                raw_in_2;
  logic                clr_glitch;
  logic                lvl_1;
  logic                lvl_2;
  logic                pulse_1;
  logic                pulse_2;
  logic [GLITCH_W-1:0] glitch_cnt_1;
  logic [GLITCH_W-1:0] glitch_cnt_2;
  modport master (
    output raw_in_1, raw_in_2, clr_glitch,
    input  lvl_1, lvl_2, pulse_1, pulse_2, glitch_cnt_1, glitch_cnt_2
  );
  modport slave (
    input  raw_in_1, raw_in_2, clr_glitch,
    output lvl_1, lvl_2, pulse_1, pulse_2, glitch_cnt_1, glitch_cnt_2
  );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: per channel 2-flop sync, 4-state debounce FSM, rising-edge pulse and saturating glitch counter
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input logic                 clk,
  input logic                 rst,
  input_conditioner_if.slave  bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_e;
  logic [1:0]                raw;
  logic [1:0]                lvl_v;
  logic [1:0]                pul_v;
  logic [1:0][GLITCH_W-1:0]  gc_v;
  assign raw = {bus.raw_in_2, bus.raw_in_1};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic                sy1_q, sy2_q;
    state_e              st_q, st_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                lvl_q, lvl_d;
    logic                pulse_q, pulse_d;
    logic [GLITCH_W-1:0] g_q, g_d;
    logic                abort;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sy1_q   <= 1'b0;
        sy2_q   <= 1'b0;
        st_q    <= STABLE_LO;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        pulse_q <= 1'b0;
        g_q     <= '0;
      end else begin
        sy1_q   <= raw[c];
        sy2_q   <= sy1_q;
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        pulse_q <= pulse_d;
        g_q     <= g_d;
      end
    end
    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      pulse_d = 1'b0;
      abort   = 1'b0;
      case (st_q)
        STABLE_LO: if (sy2_q) begin
          st_d  = WAIT_HI;
          cnt_d = CW'(1);
        end
        WAIT_HI: if (!sy2_q) begin
          st_d  = STABLE_LO;
          abort = 1'b1;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          st_d    = STABLE_HI;
          lvl_d   = 1'b1;
          pulse_d = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
        STABLE_HI: if (!sy2_q) begin
          st_d  = WAIT_LO;
          cnt_d = CW'(1);
        end
        WAIT_LO: if (sy2_q) begin
          st_d  = STABLE_HI;
          abort = 1'b1;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          st_d  = STABLE_LO;
          lvl_d = 1'b0;
        end else cnt_d = cnt_q + CW'(1);
        default: begin
          st_d  = STABLE_LO;
          lvl_d = 1'b0;
        end
      endcase
      // clear has priority over a same-cycle abort
      g_d = bus.clr_glitch ? '0 : (abort && !(&g_q)) ? g_q + GLITCH_W'(1) : g_q;
    end
    assign lvl_v[c] = lvl_q;
    assign pul_v[c] = pulse_q;
    assign gc_v[c]  = g_q;
  end
  assign bus.lvl_1        = lvl_v[0];
  assign bus.lvl_2        = lvl_v[1];
  assign bus.pulse_1      = pul_v[0];
  assign bus.pulse_2      = pul_v[1];
  assign bus.glitch_cnt_1 = gc_v[0];
  assign bus.glitch_cnt_2 = gc_v[1];
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed stimulus with an event scoreboard for level changes and pulses
module tb_input_conditioner;
  typedef struct {
    int ch;
    bit p;
    bit v;
    int e;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_n = 0;
  int   vec = 0;
  int   fail = 0;
  ev_t  ev_q[$];
  logic [1:0] pl = 2'b00;
  input_conditioner_if #(.GLITCH_W(8)) bus();
  input_conditioner #(.DEBOUNCE_CYCLES(4), .GLITCH_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask
  task automatic push(input int ch, input bit p, input bit v, input int e);
    ev_t x;
    x.ch = ch;
    x.p  = p;
    x.v  = v;
    x.e  = e;
    ev_q.push_back(x);
  endtask
  task automatic obs(input int ch, input bit p, input bit v);
    ev_t x;
    vec++;
    if (ev_q.size() == 0) begin
      fail++;
      $display("FAIL event: got ch%0d pulse=%0d lvl=%0d at edge %0d, expected no event", ch + 1, p, v, edge_n);
    end else begin
      x = ev_q.pop_front();
      if (x.ch != ch || x.p != p || x.v != v || x.e != edge_n) begin
        fail++;
        $display("FAIL event: got ch%0d pulse=%0d lvl=%0d at edge %0d, expected ch%0d pulse=%0d lvl=%0d at edge %0d",
                 ch + 1, p, v, edge_n, x.ch + 1, x.p, x.v, x.e);
      end
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pulse_1) obs(0, 1'b1, 1'b1);
      if (bus.lvl_1 != pl[0]) obs(0, 1'b0, bus.lvl_1);
      if (bus.pulse_2) obs(1, 1'b1, 1'b1);
      if (bus.lvl_2 != pl[1]) obs(1, 1'b0, bus.lvl_2);
    end
    pl <= {bus.lvl_2, bus.lvl_1};
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_lvl"}, {bus.lvl_2, bus.lvl_1}, 0);
    chk({tag, "_pulse"}, {bus.pulse_2, bus.pulse_1}, 0);
    chk({tag, "_gc1"}, bus.glitch_cnt_1, 0);
    chk({tag, "_gc2"}, bus.glitch_cnt_2, 0);
  endtask
  initial begin
    bus.raw_in_1   = 1'($urandom_range(1));
    bus.raw_in_2   = 1'($urandom_range(1));
    bus.clr_glitch = 1'b0;
    tick(3);
    chk_all_zero("reset");
    bus.raw_in_1 = 1'b0;
    bus.raw_in_2 = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(20);
    chk_all_zero("idle20");
    // short excursions of 2 and 3 samples are rejected
    bus.raw_in_1 = 1'b1;
    tick(2);
    bus.raw_in_1 = 1'b0;
    tick(10);
    chk("glitch2_gc1", bus.glitch_cnt_1, 1);
    bus.raw_in_1 = 1'b1;
    tick(3);
    bus.raw_in_1 = 1'b0;
    tick(10);
    chk("glitch3_gc1", bus.glitch_cnt_1, 2);
    chk("glitch_lvl1", bus.lvl_1, 0);
    bus.raw_in_1 = 1'b1;
    push(0, 1'b1, 1'b1, edge_n + 6);
    push(0, 1'b0, 1'b1, edge_n + 6);
    tick(12);
    chk("rise_gc1", bus.glitch_cnt_1, 2);
    chk("rise_ch2", {bus.lvl_2, bus.pulse_2}, 0);
    chk("rise_gc2", bus.glitch_cnt_2, 0);
    bus.raw_in_1 = 1'b0;
    tick(2);
    bus.raw_in_1 = 1'b1;
    tick(10);
    chk("glitch_hi_gc1", bus.glitch_cnt_1, 3);
    chk("glitch_hi_lvl1", bus.lvl_1, 1);
    bus.raw_in_1 = 1'b0;
    push(0, 1'b0, 1'b0, edge_n + 6);
    tick(12);
    chk("fall_lvl1", bus.lvl_1, 0);
    // exactly DEBOUNCE_CYCLES samples high: rises, then falls 4 edges later
    bus.raw_in_1 = 1'b1;
    push(0, 1'b1, 1'b1, edge_n + 6);
    push(0, 1'b0, 1'b1, edge_n + 6);
    push(0, 1'b0, 1'b0, edge_n + 10);
    tick(4);
    bus.raw_in_1 = 1'b0;
    tick(12);
    chk("exact4_gc1", bus.glitch_cnt_1, 3);
    for (int i = 1; i <= 260; i++) begin
      bus.raw_in_2 = 1'b1;
      tick(2);
      bus.raw_in_2 = 1'b0;
      tick(4);
      if (i == 254) chk("sat254_gc2", bus.glitch_cnt_2, 254);
      if (i == 255) chk("sat255_gc2", bus.glitch_cnt_2, 255);
    end
    chk("sat260_gc2", bus.glitch_cnt_2, 255);
    chk("sat_gc1", bus.glitch_cnt_1, 3);
    bus.raw_in_2 = 1'b1;
    tick(2);
    bus.raw_in_2 = 1'b0;
    tick(2);
    bus.clr_glitch = 1'b1;
    tick(1);
    bus.clr_glitch = 1'b0;
    chk("clr_gc2", bus.glitch_cnt_2, 0);
    chk("clr_gc1", bus.glitch_cnt_1, 0);
    tick(4);
    chk("clr_hold_gc2", bus.glitch_cnt_2, 0);
    bus.raw_in_2 = 1'b1;
    tick(2);
    bus.raw_in_2 = 1'b0;
    tick(6);
    chk("after_clr_gc2", bus.glitch_cnt_2, 1);
    bus.raw_in_1 = 1'b1;
    bus.raw_in_2 = 1'b1;
    push(0, 1'b1, 1'b1, edge_n + 6);
    push(0, 1'b0, 1'b1, edge_n + 6);
    push(1, 1'b1, 1'b1, edge_n + 6);
    push(1, 1'b0, 1'b1, edge_n + 6);
    tick(10);
    bus.raw_in_1 = 1'b0;
    bus.raw_in_2 = 1'b0;
    push(0, 1'b0, 1'b0, edge_n + 6);
    push(1, 1'b0, 1'b0, edge_n + 6);
    tick(10);
    chk("both_lvl", {bus.lvl_2, bus.lvl_1}, 0);
    // reset lands while channel 1 is in WAIT_HI
    bus.raw_in_1 = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick(2);
    rst = 1'b0;
    push(0, 1'b1, 1'b1, edge_n + 6);
    push(0, 1'b0, 1'b1, edge_n + 6);
    tick(10);
    chk("rst_mid_gc1", bus.glitch_cnt_1, 0);
    bus.raw_in_1 = 1'b0;
    push(0, 1'b0, 1'b0, edge_n + 6);
    tick(10);
    chk("queue_drained", ev_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
# input_conditioner

Two-channel input conditioner that sits directly upstream of the one-hot control FSM and drives its two qualifying inputs. Each channel takes a raw asynchronous input, synchronizes it into `clk`, debounces it, and produces two outputs: a clean level and a single-cycle rising-edge pulse. The FSM can be fed either output. Each channel also keeps a saturating glitch counter for bring-up diagnostics.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive synchronized samples that must agree before the debounced level changes. Legal range 2..255.
- `GLITCH_W`, default 8: width of each glitch counter. The counter saturates at 2^GLITCH_W-1.

- `clk` (in, 1): clock, rising-edge.
- `rst` (in, 1): reset, asynchronous, active-high.
- `raw_in_1`, `raw_in_2` (in, 1 each): raw inputs, asynchronous to `clk`.
- `clr_glitch` (in, 1): synchronous clear of both glitch counters.
- `lvl_1`, `lvl_2` (out, 1 each): debounced, registered levels.
- `pulse_1`, `pulse_2` (out, 1 each): one-cycle pulse on each debounced rising edge.
- `glitch_cnt_1`, `glitch_cnt_2` (out, GLITCH_W each): count of aborted transitions per channel.

## Operation
- The two channels are identical and fully independent. No signal is shared between them except `clk`, `rst` and `clr_glitch`.
- Synchronizer: a 2-flop chain per channel, `raw` -> `sy1` -> `sy2`. `sy2` is the sample `s` used by the debounce FSM.
- Debounce FSM, 4 states, with counter `cnt` of width clog2(DEBOUNCE_CYCLES)+1:
  - STABLE_LO:
    - `s`=1: go to WAIT_HI, `cnt`<=1.
    - `s`=0: stay.
  - WAIT_HI:
    - `s`=0: go to STABLE_LO and increment the glitch counter.
    - `s`=1 and `cnt`==DEBOUNCE_CYCLES-1: go to STABLE_HI, `lvl`<=1, `pulse`<=1.
    - `s`=1 otherwise: `cnt`++.
  - STABLE_HI:
    - `s`=0: go to WAIT_LO, `cnt`<=1.
    - `s`=1: stay.
  - WAIT_LO:
    - `s`=1: go to STABLE_HI and increment the glitch counter.
    - `s`=0 and `cnt`==DEBOUNCE_CYCLES-1: go to STABLE_LO, `lvl`<=0. No pulse is produced.
    - `s`=0 otherwise: `cnt`++.
- An unreachable state encoding recovers to STABLE_LO with `lvl`=0 on the next edge.
- `pulse` is registered and is high for exactly one cycle; it is cleared on every edge where no rising transition completes.
- Glitch counter:
  - Increments by 1 on each aborted WAIT state and saturates at all-ones.
  - `clr_glitch`=1 forces the counter to 0 on the next edge. If a clear and an increment occur in the same cycle, the clear wins and the result is 0.

## Timing
- Reset values: `sy1`=`sy2`=0, state STABLE_LO, `cnt`=0, `lvl_*`=0, `pulse_*`=0, `glitch_cnt_*`=0. All registers are reset asynchronously.
- Reset asserted mid-WAIT state:
  - All state returns immediately to the reset values. No pulse is produced and no glitch is counted.
  - After `rst` deasserts, a `raw` held high restarts the full latency count.
- Rise latency, with edge 0 defined as the first `clk` edge that samples `raw`=1:
  - Edge 0: `sy1`=1. Edge 1: `sy2`=1. Edge 2: WAIT_HI, `cnt`=1.
  - Edge DEBOUNCE_CYCLES+1: `lvl`=1 and `pulse`=1.
  - Edge DEBOUNCE_CYCLES+2: `pulse`=0.
- Fall latency is identical, with `lvl`=0 after edge DEBOUNCE_CYCLES+1 and no pulse.
- Glitch rejection: a `raw` excursion seen in fewer than DEBOUNCE_CYCLES consecutive `s` samples never changes `lvl`.
- Minimum spacing between two pulses on one channel is 2*DEBOUNCE_CYCLES cycles.
- All outputs are driven directly from flops; there is no combinational path from any input to any output.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and GLITCH_W=8 unless stated otherwise.
- Reset: assert `rst` with random `raw_*` -> every output 0. After deassert with `raw`=0 held for 20 cycles, every output stays 0.
- Clean rise: `raw_in_1` 0->1 before edge 0 -> `lvl_1`=1 after edge 5; `pulse_1`=1 only between edges 5 and 6; `glitch_cnt_1`=0; all channel-2 outputs unchanged.
- Glitch: `raw_in_1` high for 2 cycles then low -> `lvl_1` stays 0, `pulse_1` never asserts, `glitch_cnt_1`=1.
- Fall from the high level: `raw_in_1` 1->0 -> `lvl_1`=0 after edge 5 from the first low sample, and no pulse.
- Saturation and clear:
  - 260 glitches on channel 2 -> `glitch_cnt_2`=255.
  - `clr_glitch` pulsed in a cycle where a glitch aborts -> `glitch_cnt_2`=0.
- Independence and reset mid-operation:
  - Both raw inputs rise on the same edge -> `pulse_1` and `pulse_2` assert in the same cycle.
  - `rst` asserted while in WAIT_HI, `raw` held high -> no pulse; after deassert, `lvl` rises 6 edges later.
